// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer and its shifter.
//   state_e   : sequencer FSM states (2-bit encoding)
//   DIR_RIGHT : leftright value that shifts toward the LSB
//   DIR_LEFT  : leftright value that shifts toward the MSB
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shifter.sv
// Parallel-load, bidirectional shift register driven by shift_sequencer.
// Ports:
//   clock     : system clock, rising edge
//   reset     : synchronous active-low reset, clears the contents
//   pdatain   : parallel load value
//   pload     : load pdatain at the next edge (has priority over enable)
//   enable    : shift one position at the next edge
//   leftright : DIR_LEFT shifts toward MSB, DIR_RIGHT toward LSB
//   serialin  : bit shifted into the vacated end
//   pdataout  : current contents
module shifter
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pdatain,
  input  logic             pload,
  input  logic             enable,
  input  logic             leftright,
  input  logic             serialin,
  output logic [WIDTH-1:0] pdataout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q <= '0;
    end else if (pload) begin
      r_q <= pdatain;
    end else if (enable) begin
      if (leftright == DIR_LEFT) r_q <= {r_q[WIDTH-2:0], serialin};
      else                       r_q <= {serialin, r_q[WIDTH-1:1]};
    end
  end

  assign pdataout = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for one parallel-load bidirectional shifter.
// Accepts a command (optional load, then N shifts with a given direction and
// fill bit), drives the shifter pins cycle-exactly, captures the shifter
// contents at the end and pulses done; abort cancels and pulses aborted.
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_load, cmd_data   : optional parallel load value
//   cmd_dir, cmd_fill    : shift direction and serial fill bit
//   cmd_count            : number of shift cycles (0 allowed)
//   abort                : cancel the command in progress
//   sh_*                 : shifter control pins / shifter output
//   result, done         : captured contents, one-cycle completion pulse
//   aborted              : one-cycle pulse when an abort takes effect
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             sh_pload,
  output logic [WIDTH-1:0] sh_pdatain,
  output logic             sh_enable,
  output logic             sh_leftright,
  output logic             sh_serialin,
  input  logic [WIDTH-1:0] sh_pdataout,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             aborted
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic             r_fill;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_aborted;
  // Set on the first edge with reset released; keeps cmd_ready low while
  // reset is asserted even though the state is already IDLE.
  logic             r_live;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values; blocking here would let later
  // statements see already-updated state and break the edge semantics.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_dir     <= DIR_RIGHT;
      r_fill    <= 1'b0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (abort && r_state != IDLE) begin
        // Shifts already performed stay in the shifter; result is kept.
        r_state   <= IDLE;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (cmd_valid && cmd_ready) begin
              r_data <= cmd_data;
              r_dir  <= cmd_dir;
              r_fill <= cmd_fill;
              r_cnt  <= cmd_count;
              if (cmd_load)            r_state <= LOAD;
              else if (cmd_count != 0) r_state <= SHIFT;
              else                     r_state <= DONE;
            end
          end
          LOAD: begin
            r_state <= (r_cnt != 0) ? SHIFT : DONE;
          end
          SHIFT: begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) r_state <= DONE;
          end
          DONE: begin
            // The last shift landed on the previous edge, so sh_pdataout
            // is final during this cycle.
            r_result <= sh_pdataout;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded from registered state only; LOAD and SHIFT are
  // distinct states, so pload and enable can never be high together.
  assign cmd_ready    = r_live && (r_state == IDLE);
  assign sh_pload     = (r_state == LOAD);
  assign sh_enable    = (r_state == SHIFT);
  assign sh_pdatain   = r_data;
  assign sh_leftright = r_dir;
  assign sh_serialin  = r_fill;
  assign result       = r_result;
  assign done         = r_done;
  assign aborted      = r_aborted;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_load = 1'b0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_dir = 1'b0;
  logic             cmd_fill = 1'b0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             abort = 1'b0;
  logic             sh_pload;
  logic [WIDTH-1:0] sh_pdatain;
  logic             sh_enable;
  logic             sh_leftright;
  logic             sh_serialin;
  logic [WIDTH-1:0] sh_pdataout;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             aborted;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic             ab;
    logic [WIDTH-1:0] res;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_data(cmd_data), .cmd_dir(cmd_dir),
    .cmd_fill(cmd_fill), .cmd_count(cmd_count), .abort(abort),
    .sh_pload(sh_pload), .sh_pdatain(sh_pdatain), .sh_enable(sh_enable),
    .sh_leftright(sh_leftright), .sh_serialin(sh_serialin),
    .sh_pdataout(sh_pdataout),
    .result(result), .done(done), .aborted(aborted)
  );

  shifter #(.WIDTH(WIDTH)) u_shifter (
    .clock(clock), .reset(reset),
    .pdatain(sh_pdatain), .pload(sh_pload), .enable(sh_enable),
    .leftright(sh_leftright), .serialin(sh_serialin),
    .pdataout(sh_pdataout)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done/aborted pulse pops one expected entry.
  always @(negedge clock) begin
    if (reset) check("pload_enable_exclusive", 32'(sh_pload & sh_enable), 0);
    if (done || aborted) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pulse", {30'd0, done, aborted}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_kind", {30'd0, done, aborted}, e.ab ? 32'd1 : 32'd2);
        check("sb_result", 32'(result), 32'(e.res));
      end
    end
  end

  // Issue one command starting at a negedge; returns at the negedge of the
  // done/aborted cycle so the next call can be accepted back-to-back.
  task automatic issue(input string name, input logic ld,
                       input logic [WIDTH-1:0] data, input logic dir,
                       input logic fill, input logic [CNT_W-1:0] cnt,
                       input int abort_at, input logic [WIDTH-1:0] exp_res);
    int w = 0;
    int fin = 0;
    int np = 0;
    int ne = 0;
    sb.push_back('{ab: (abort_at != 0), res: exp_res});
    cmd_load = ld; cmd_data = data; cmd_dir = dir;
    cmd_fill = fill; cmd_count = cnt; cmd_valid = 1'b1;
    while (!cmd_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    check({name, "_ready"}, 32'(cmd_ready), 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_dir   = ~dir;
    cmd_fill  = ~fill;
    cmd_count = ~cnt;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      abort = 1'b0;
      if (sh_pload) np++;
      if (sh_enable) begin
        ne++;
        if (ne == abort_at) abort = 1'b1;
      end
      if (done || aborted) begin
        fin = n;
        break;
      end
    end
    abort = 1'b0;
    check({name, "_pload_cycles"}, 32'(np), 32'(ld));
    if (abort_at == 0) begin
      check({name, "_edges_to_done"}, 32'(fin - 1), 32'(ld) + 32'(cnt) + 1);
      check({name, "_enable_cycles"}, 32'(ne), 32'(cnt));
      check({name, "_ready_in_done"}, 32'(cmd_ready), 1);
    end else begin
      check({name, "_edges_to_abort"}, 32'(fin - 1), 32'(ld) + 32'(abort_at));
      check({name, "_enable_cycles"}, 32'(ne), 32'(abort_at));
      check({name, "_enable_after_abort"}, 32'(sh_enable), 0);
      check({name, "_ready_after_abort"}, 32'(cmd_ready), 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 5 cycles: every output must read 0.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("reset_outputs",
            32'({cmd_ready, sh_pload, sh_pdatain, sh_enable, sh_leftright,
                 sh_serialin, result, done, aborted}), 0);
    end
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", 32'(cmd_ready), 1);
    check("no_done_after_reset", 32'({done, aborted}), 0);

    // 1010 right, fill 0, two shifts: 0101, 0010.
    issue("load_r2", 1'b1, 4'b1010, DIR_RIGHT, 1'b0, 3'd2, 0, 4'b0010);
    // No load, zero shifts: captures current contents.
    issue("noop", 1'b0, 4'b1111, DIR_LEFT, 1'b1, 3'd0, 0, 4'b0010);
    // 1010 left, fill 1, one shift: 0101.
    issue("load_l1", 1'b1, 4'b1010, DIR_LEFT, 1'b1, 3'd1, 0, 4'b0101);
    // Back-to-back from the done cycle: 0101 right x4 fill 0 -> 0000.
    issue("b2b_r4", 1'b0, 4'b1001, DIR_RIGHT, 1'b0, 3'd4, 0, 4'b0000);
    // 1111 right, fill 0, abort in the 3rd shift cycle: 3 shifts -> 0001.
    issue("abort", 1'b1, 4'b1111, DIR_RIGHT, 1'b0, 3'd7, 3, 4'b0000);
    check("abort_shifter_contents", 32'(sh_pdataout), 32'(4'b0001));
    repeat (3) @(negedge clock);

    // Reset during SHIFT: outputs clear next cycle, no pulses.
    cmd_load = 1'b1; cmd_data = 4'b1001; cmd_dir = DIR_LEFT;
    cmd_fill = 1'b0; cmd_count = 3'd5; cmd_valid = 1'b1;
    check("midreset_ready", 32'(cmd_ready), 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    begin
      int ne = 0;
      for (int n = 0; n < 10 && ne < 2; n++) begin
        @(negedge clock);
        if (sh_enable) ne++;
      end
      check("midreset_reached_shift", 32'(ne), 2);
    end
    reset = 1'b0;
    @(negedge clock);
    check("midreset_outputs",
          32'({cmd_ready, sh_pload, sh_pdatain, sh_enable, sh_leftright,
               sh_serialin, result, done, aborted}), 0);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_ready_after", 32'(cmd_ready), 1);
    check("midreset_idle_no_enable", 32'({sh_pload, sh_enable}), 0);

    // Recovery: 0110 left, fill 1, three shifts: 1101, 1011, 0111.
    issue("recover_l3", 1'b1, 4'b0110, DIR_LEFT, 1'b1, 3'd3, 0, 4'b0111);
    repeat (3) @(negedge clock);

    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller for the team's 4-bit parallel-load, bidirectional shift register (ports pdatain, pload, enable, leftright, serialin, pdataout).
- Accepts one command over a valid/ready handshake: optional parallel load, then N shifts in a given direction with a given fill bit.
- Drives the shifter control pins cycle-exactly, captures pdataout when the command finishes, and reports completion with a one-cycle done pulse.
- Sits between the test or host logic and one shifter instance; replaces hand-timed pload/enable pulses.

Parameters:
- WIDTH, 4, shifter data width.
- CNT_W, 3, width of the shift-count field (0..2^CNT_W-1 shifts per command).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (IDLE only).
- cmd_load  in  1  1 = parallel-load cmd_data before shifting.
- cmd_data  in  WIDTH  parallel load value.
- cmd_dir  in  1  shift direction, driven to leftright (0 = right/toward LSB, 1 = left/toward MSB).
- cmd_fill  in  1  serial-in bit used for every shift of this command.
- cmd_count  in  CNT_W  number of shift cycles.
- abort  in  1  cancel the command in progress.
- sh_pload  out  1  to shifter pload.
- sh_pdatain  out  WIDTH  to shifter pdatain.
- sh_enable  out  1  to shifter enable.
- sh_leftright  out  1  to shifter leftright.
- sh_serialin  out  1  to shifter serialin.
- sh_pdataout  in  WIDTH  from shifter pdataout.
- result  out  WIDTH  captured shifter contents at command end.
- done  out  1  one-cycle pulse; result valid in the same cycle.
- aborted  out  1  one-cycle pulse when an abort takes effect.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, counter=0, all outputs 0 including cmd_ready, result, done and aborted. cmd_ready rises in the first cycle after reset releases.
- All outputs are registered or decoded from registered state only. There is no combinational path from cmd_* to sh_*.
- Accept occurs at an edge where state==IDLE && cmd_valid && cmd_ready. At that edge the sequencer latches data, dir, fill and count, and sets counter=cmd_count.
  - cmd_load=1: go to LOAD.
  - cmd_load=0 and count>0: go to SHIFT.
  - cmd_load=0 and count==0: go to DONE.
- LOAD (1 cycle): sh_pload=1, sh_pdatain=latched data, sh_enable=0. Next state is SHIFT if count>0, else DONE.
- SHIFT (count cycles): sh_enable=1, sh_leftright=latched dir, sh_serialin=latched fill, sh_pload=0. Counter decrements each edge; the edge on which counter==1 goes to DONE.
- DONE (1 cycle): all sh_* controls 0. The edge latches result<=sh_pdataout, sets done=1 for the following cycle, and goes to IDLE.
- Latency: done is high in the cycle after edge (load+count+1) counted from the accept edge. Load+2 shifts gives 4 edges; no load with 0 shifts gives 1 edge.
- Back-to-back: cmd_ready is high in the done cycle, so a new command can be accepted then.
- sh_pload and sh_enable are never high in the same cycle.
- sh_leftright and sh_serialin hold their latched values for the whole command and keep the last values in IDLE.
- abort (any non-IDLE state, sampled at an edge):
  - next state is IDLE; sh_pload and sh_enable go 0.
  - aborted=1 for one cycle; no done; result unchanged.
  - shifter contents are whatever shifts already completed.
  - abort in IDLE is ignored.
  - abort and accept in the same IDLE edge: accept wins.
- cmd_valid held while not ready: ignored with no side effects. cmd_* fields may change freely outside the accept edge.
- reset mid-command: same as the reset state. No done or aborted pulse.

Decomposition:
- Shared package shift_seq_pkg holds:
  - state enum IDLE/LOAD/SHIFT/DONE (2-bit encoding);
  - localparams DIR_RIGHT=0, DIR_LEFT=1.
- No sub-module: single FSM plus down-counter.
- The bench instantiates shift_sequencer together with the existing 4-bit shifter, with the same clock and reset.

Test Plan:
- Reset held for 5 cycles, then released → all outputs 0 during reset; cmd_ready=1 on the first cycle after release; no done.
- Load 4'b1010, dir=0, fill=0, count=2 → sh_pload high for exactly 1 cycle, sh_enable high for exactly 2 cycles; done after 4 edges from accept; result=4'b0010.
- Load 4'b1010, dir=1, fill=1, count=1 → result=4'b0101. Then, back-to-back in the done cycle, no load, dir=0, fill=0, count=4 → result=4'b0000.
- No load, count=0 → done 1 edge after accept; result equals current shifter contents; sh_enable and sh_pload never asserted.
- Load 4'b1111, dir=0, fill=0, count=7, abort asserted in the 3rd SHIFT cycle → aborted pulse; no done; sh_enable low on the next cycle; result unchanged; cmd_ready=1.
- reset driven low during SHIFT → next cycle all outputs 0 and state IDLE. A full-run checker asserts throughout that sh_pload and sh_enable are never high together.
